// File: rtl/mat_op_pkg.sv
// rtl/mat_op_pkg.sv - shared states, write-source codes, opcodes and bank-select helper for mat_op_sequencer
package mat_op_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LAUNCH,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [1:0] WR_SRC_NONE   = 2'b00;
  localparam logic [1:0] WR_SRC_ENCODE = 2'b01;
  localparam logic [1:0] WR_SRC_DECODE = 2'b10;

  localparam logic [2:0] OPC_ENC_DEC = 3'b110;

  // Two-bit bank select to one-hot {mem1_1, mem1_0, mem0_1, mem0_0}
  function automatic logic [3:0] bank_onehot(input logic [1:0] sel);
    bank_onehot = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/mat_op_sequencer_desc_fetch_pipe.sv
// rtl/mat_op_sequencer_desc_fetch_pipe.sv - read-tag pipeline producing capture strobes RD_LAT cycles after issue
module desc_fetch_pipe #(
  parameter int RD_LAT = 1,
  parameter int SLOT_W = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [SLOT_W-1:0] issue_slot,
  output logic              cap_valid,
  output logic [SLOT_W-1:0] cap_slot
);

  // Return data is sampled on the edge closing the RD_LAT-th cycle of a read,
  // so the tag travels through RD_LAT-1 registers; RD_LAT=1 is a pass-through.
  generate
    if (RD_LAT == 1) begin : g_comb
      assign cap_valid = issue_valid & ~flush;
      assign cap_slot  = issue_slot;
    end else begin : g_pipe
      logic [RD_LAT-2:0] vld;
      logic [SLOT_W-1:0] slot [0:RD_LAT-2];

      // Shift {valid, slot}; flush drops every read still in flight
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld <= '0;
          for (int i = 0; i < RD_LAT - 1; i++) slot[i] <= '0;
        end else if (flush) begin
          vld <= '0;
        end else begin
          vld[0]  <= issue_valid;
          slot[0] <= issue_slot;
          for (int i = 1; i < RD_LAT - 1; i++) begin
            vld[i]  <= vld[i-1];
            slot[i] <= slot[i-1];
          end
        end
      end

      assign cap_valid = vld[RD_LAT-2] & ~flush;
      assign cap_slot  = slot[RD_LAT-2];
    end
  endgenerate

endmodule

// File: rtl/mat_op_sequencer.sv
// rtl/mat_op_sequencer.sv - matrix-op controller top (optional RUN watchdog via MAT_OP_WATCHDOG_EN)
module mat_op_sequencer
  import mat_op_pkg::*;
#(
  parameter int OPC_W            = 3,
  parameter int IDX_W            = 4,
  parameter int NUM_OPS          = 3,
  parameter int NUM_LOOPS        = 3,
  parameter int LOOP_W           = 11,
  parameter int ADDR_WIDTH       = 12,
  parameter int UINST_ADDR_WIDTH = 8,
  parameter int RD_LAT           = 1,
  parameter int TIMEOUT          = 4096,
  localparam int INST_W          = OPC_W + NUM_OPS*IDX_W + 1
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [INST_W-1:0]                     inst,
  input  logic                                  inst_valid,
  output logic                                  inst_ready,
  input  logic                                  abort,
  output logic                                  desc_rd_en,
  output logic [ADDR_WIDTH-1:0]                 desc_addr,
  input  logic [ADDR_WIDTH+1:0]                 desc_rd_data,
  output logic [OPC_W-1:0]                      uentry_addr,
  input  logic [UINST_ADDR_WIDTH-1:0]           uentry_data,
  output logic [NUM_OPS*(ADDR_WIDTH+2)-1:0]     op_base,
  output logic [ADDR_WIDTH+1:0]                 dst_base,
  output logic [NUM_LOOPS*LOOP_W-1:0]           loop_bound,
  output logic [UINST_ADDR_WIDTH-1:0]           upc_start,
  output logic                                  start_pulse,
  input  logic                                  ucode_done,
  output logic [3:0]                            mem_wr_en,
  output logic [1:0]                            wr_src,
  output logic                                  busy,
  output logic                                  op_done,
  output logic                                  err
);

  localparam int BASE_W    = ADDR_WIDTH + 2;
  localparam int NUM_RD    = NUM_OPS + NUM_LOOPS;
  localparam int FETCH_LEN = NUM_RD + RD_LAT - 1;
  localparam int CNT_W     = $clog2(FETCH_LEN + 1);
  localparam int SLOT_W    = $clog2(NUM_RD + 1);
  localparam int LA_W      = ADDR_WIDTH - 1;

  state_t                              state, state_d;
  logic [INST_W-1:0]                   inst_q;
  logic [CNT_W-1:0]                    fcnt;
  logic [NUM_OPS-1:0][BASE_W-1:0]      op_base_q;
  logic [NUM_LOOPS-1:0][LOOP_W-1:0]    loop_q;
  logic [IDX_W-1:0]                    idx_f [NUM_OPS];
  logic [OPC_W-1:0]                    opcode;
  logic [SLOT_W-1:0]                   issue_slot, cap_slot;
  logic                                cap_valid;
  logic                                wd_expire;

  assign opcode = inst_q[INST_W-1 -: OPC_W];

  generate
    for (genvar k = 0; k < NUM_OPS; k++) begin : g_idx
      assign idx_f[k] = inst_q[INST_W-1-OPC_W-k*IDX_W -: IDX_W];
    end
  endgenerate

  assign op_base    = op_base_q;
  assign loop_bound = loop_q;
  assign dst_base   = op_base_q[NUM_OPS-1] ^ (BASE_W'(1) << ADDR_WIDTH);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Next state and per-state strobes; abort overrides everything outside IDLE
  always_comb begin
    state_d     = state;
    inst_ready  = 1'b0;
    busy        = 1'b1;
    start_pulse = 1'b0;
    op_done     = 1'b0;
    err         = wd_expire;
    case (state)
      ST_IDLE: begin
        inst_ready = 1'b1;
        busy       = 1'b0;
        if (inst_valid) state_d = ST_FETCH;
      end
      ST_FETCH:  if (fcnt == CNT_W'(FETCH_LEN - 1)) state_d = ST_LAUNCH;
      ST_LAUNCH: begin
        start_pulse = ~abort;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (ucode_done)     state_d = ST_DONE;
        else if (wd_expire) state_d = ST_IDLE;
      end
      ST_DONE: begin
        op_done = ~abort;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) state_d = ST_IDLE;
  end

  // Instruction latch on handshake and FETCH cycle counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_q <= '0;
      fcnt   <= '0;
    end else begin
      if (state == ST_IDLE && inst_valid) inst_q <= inst;
      if (state == ST_FETCH) fcnt <= fcnt + 1'b1;
      else                   fcnt <= '0;
    end
  end

  // Read issue: operand indices first, then the loop-bound area, one per cycle
  always_comb begin
    desc_rd_en  = 1'b0;
    desc_addr   = '0;
    uentry_addr = '0;
    issue_slot  = '0;
    if (state == ST_FETCH && fcnt < CNT_W'(NUM_RD)) begin
      desc_rd_en = 1'b1;
      issue_slot = SLOT_W'(fcnt);
      for (int k = 0; k < NUM_OPS; k++)
        if (fcnt == CNT_W'(k)) desc_addr = ADDR_WIDTH'(idx_f[k]);
      for (int j = 0; j < NUM_LOOPS; j++)
        if (fcnt == CNT_W'(NUM_OPS + j)) desc_addr = {1'b1, LA_W'(j)};
    end
    if (state == ST_FETCH && fcnt == '0) uentry_addr = opcode;
  end

  desc_fetch_pipe #(
    .RD_LAT (RD_LAT),
    .SLOT_W (SLOT_W)
  ) u_pipe (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (abort),
    .issue_valid (desc_rd_en),
    .issue_slot  (issue_slot),
    .cap_valid   (cap_valid),
    .cap_slot    (cap_slot)
  );

  // Route each tagged return into its operand or loop-bound slot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_base_q <= '0;
      loop_q    <= '0;
    end else if (cap_valid) begin
      for (int k = 0; k < NUM_OPS; k++)
        if (cap_slot == SLOT_W'(k)) op_base_q[k] <= desc_rd_data;
      for (int j = 0; j < NUM_LOOPS; j++)
        if (cap_slot == SLOT_W'(NUM_OPS + j)) loop_q[j] <= desc_rd_data[LOOP_W-1:0];
    end
  end

  // Entry point arrives alongside the first descriptor return
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                               upc_start <= '0;
    else if (state == ST_DONE)               upc_start <= '0;
    else if (cap_valid && cap_slot == '0)    upc_start <= uentry_data;
  end

  // Write-port select: set in LAUNCH so it is live from the first RUN cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_wr_en <= '0;
      wr_src    <= WR_SRC_NONE;
    end else if (abort || wd_expire || state == ST_DONE) begin
      mem_wr_en <= '0;
      wr_src    <= WR_SRC_NONE;
    end else if (state == ST_LAUNCH) begin
      mem_wr_en <= opcode[OPC_W-1] ? bank_onehot(dst_base[BASE_W-1 -: 2]) : 4'b0000;
      if (opcode == OPC_W'(OPC_ENC_DEC))
        wr_src <= inst_q[0] ? WR_SRC_DECODE : WR_SRC_ENCODE;
      else
        wr_src <= WR_SRC_NONE;
    end
  end

`ifdef MAT_OP_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wd_cnt;

  // Count RUN cycles from zero on every entry into RUN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 wd_cnt <= '0;
    else if (state != ST_RUN)  wd_cnt <= '0;
    else                       wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_expire = (state == ST_RUN) && !ucode_done && !abort &&
                     (wd_cnt == WD_W'(TIMEOUT - 1));
`else
  assign wd_expire = 1'b0;
`endif

endmodule

// File: tb/tb_mat_op_sequencer.sv
// tb/tb_mat_op_sequencer.sv - self-checking bench for mat_op_sequencer at RD_LAT 1 and 3
module tb_mat_op_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] inst;
  logic        iv [2];
  logic        ab [2];
  logic        ud [2];
  logic        ready [2];
  logic        rden [2];
  logic        start [2];
  logic        busy [2];
  logic        done [2];
  logic        err [2];
  logic [11:0] daddr [2];
  logic [13:0] rdata [2];
  logic [2:0]  uaddr [2];
  logic [7:0]  udata [2];
  logic [7:0]  upc [2];
  logic [41:0] base [2];
  logic [13:0] dst [2];
  logic [32:0] loops [2];
  logic [3:0]  we [2];
  logic [1:0]  ws [2];

  logic [13:0] desc_mem [0:4095];
  logic [7:0]  uent_mem [0:7];
  logic [11:0] h1, h2;
  logic [2:0]  uh1, uh2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mat_op_sequencer #(.RD_LAT(1), .TIMEOUT(16)) u_dut1 (
    .clk(clk), .rstn(rstn), .inst(inst), .inst_valid(iv[0]), .inst_ready(ready[0]),
    .abort(ab[0]), .desc_rd_en(rden[0]), .desc_addr(daddr[0]), .desc_rd_data(rdata[0]),
    .uentry_addr(uaddr[0]), .uentry_data(udata[0]), .op_base(base[0]), .dst_base(dst[0]),
    .loop_bound(loops[0]), .upc_start(upc[0]), .start_pulse(start[0]), .ucode_done(ud[0]),
    .mem_wr_en(we[0]), .wr_src(ws[0]), .busy(busy[0]), .op_done(done[0]), .err(err[0])
  );

  mat_op_sequencer #(.RD_LAT(3), .TIMEOUT(16)) u_dut3 (
    .clk(clk), .rstn(rstn), .inst(inst), .inst_valid(iv[1]), .inst_ready(ready[1]),
    .abort(ab[1]), .desc_rd_en(rden[1]), .desc_addr(daddr[1]), .desc_rd_data(rdata[1]),
    .uentry_addr(uaddr[1]), .uentry_data(udata[1]), .op_base(base[1]), .dst_base(dst[1]),
    .loop_bound(loops[1]), .upc_start(upc[1]), .start_pulse(start[1]), .ucode_done(ud[1]),
    .mem_wr_en(we[1]), .wr_src(ws[1]), .busy(busy[1]), .op_done(done[1]), .err(err[1])
  );

  // Memories: latency 1 answers in the issue cycle, latency 3 two cycles later
  always_ff @(posedge clk) begin
    h1  <= daddr[1];
    h2  <= h1;
    uh1 <= uaddr[1];
    uh2 <= uh1;
  end

  always_comb begin
    rdata[0] = desc_mem[daddr[0]];
    udata[0] = uent_mem[uaddr[0]];
    rdata[1] = desc_mem[h2];
    udata[1] = uent_mem[uh2];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 normal, 1 abort in 3rd FETCH cycle, 2 abort with ucode_done, 3 never done
  task automatic do_op(input int d, input logic [2:0] opc, input logic [3:0] i0,
                       input logic [3:0] i1, input logic [3:0] i2, input logic wsel,
                       input int run_cyc, input int mode);
    int          lat;
    int          cyc;
    int          saw;
    logic [13:0] eb [3];
    logic [10:0] el [3];
    logic [11:0] ea [6];
    logic [13:0] edst;
    logic [3:0]  ewe;
    logic [1:0]  ews;
    logic [7:0]  eupc;
    lat   = (d == 0) ? 1 : 3;
    ea[0] = {8'd0, i0};
    ea[1] = {8'd0, i1};
    ea[2] = {8'd0, i2};
    for (int j = 0; j < 3; j++) begin
      ea[3+j] = 12'h800 + 12'(j);
      el[j]   = desc_mem[12'h800 + 12'(j)][10:0];
      eb[j]   = desc_mem[ea[j]];
    end
    edst = eb[2] ^ 14'h1000;
    ewe  = opc[2] ? (4'b0001 << edst[13:12]) : 4'b0000;
    ews  = (opc == 3'b110) ? (wsel ? 2'b10 : 2'b01) : 2'b00;
    eupc = uent_mem[opc];

    chk("idle_ready", ready[d], 1);
    inst  = {opc, i0, i1, i2, wsel};
    iv[d] = 1'b1;
    @(negedge clk);
    iv[d] = 1'b0;
    inst  = 16'($urandom);
    cyc   = 1;
    for (int k = 0; k < 6; k++) begin
      chk("desc_rd_en", rden[d], 1);
      chk("desc_addr", daddr[d], ea[k]);
      if (k == 0) chk("uentry_addr", uaddr[d], opc);
      if (mode == 1 && k == 2) begin
        ab[d] = 1'b1;
        @(negedge clk);
        ab[d] = 1'b0;
        chk("abort_busy", busy[d], 0);
        chk("abort_ready", ready[d], 1);
        saw = 0;
        repeat (8) begin
          if (start[d] !== 1'b0) saw++;
          @(negedge clk);
        end
        chk("abort_no_start", saw, 0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    while (start[d] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("start_latency", cyc, 6 + lat);
    chk("launch_upc", upc[d], eupc);
    chk("launch_dst", dst[d], edst);
    chk("launch_we_not_yet", we[d], 0);
    for (int k = 0; k < 3; k++) begin
      chk("op_base", base[d][k*14 +: 14], eb[k]);
      chk("loop_bound", loops[d][k*11 +: 11], el[k]);
    end
    if (mode != 3) ud[d] = 1'b1;
    @(negedge clk);
    ud[d] = 1'b0;
    chk("start_one_cycle", start[d], 0);
    chk("launch_done_ignored", done[d], 0);
`ifdef MAT_OP_WATCHDOG_EN
    if (mode == 3) begin
      saw = 0;
      while (err[d] !== 1'b1 && saw < 40) begin
        @(negedge clk);
        saw++;
      end
      chk("wd_run_cycles", saw, 15);
      @(negedge clk);
      chk("wd_err_one_cycle", err[d], 0);
      chk("wd_busy", busy[d], 0);
      chk("wd_we", we[d], 0);
      chk("wd_no_done", done[d], 0);
      return;
    end
`endif
    for (int r = 0; r < run_cyc; r++) begin
      chk("run_busy", busy[d], 1);
      chk("run_we", we[d], ewe);
      chk("run_wr_src", ws[d], ews);
      chk("run_err", err[d], 0);
      @(negedge clk);
    end
    ud[d] = 1'b1;
    if (mode == 2) ab[d] = 1'b1;
    @(negedge clk);
    ud[d] = 1'b0;
    ab[d] = 1'b0;
    if (mode == 2) begin
      chk("abort_done_no_op_done", done[d], 0);
      chk("abort_done_we", we[d], 0);
      chk("abort_done_busy", busy[d], 0);
      return;
    end
    chk("op_done", done[d], 1);
    @(negedge clk);
    chk("op_done_one_cycle", done[d], 0);
    chk("post_ready", ready[d], 1);
    chk("post_we", we[d], 0);
    chk("post_wr_src", ws[d], 0);
    chk("post_upc", upc[d], 0);
    chk("post_base_hold", base[d][13:0], eb[0]);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) desc_mem[i] = 14'd0;
    for (int i = 0; i < 8; i++) uent_mem[i] = 8'd0;
    desc_mem[2]      = 14'h0100;
    desc_mem[5]      = 14'h0200;
    desc_mem[7]      = 14'h1300;
    desc_mem[12'h800] = 14'd16;
    uent_mem[6]      = 8'h20;
    uent_mem[2]      = 8'h31;
    inst = '0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0;
      ab[d] = 1'b0;
      ud[d] = 1'b0;
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", ready[d], 1);
      chk("rst_busy", busy[d], 0);
      chk("rst_start", start[d], 0);
      chk("rst_we", we[d], 0);
      chk("rst_base", base[d], 0);
      chk("rst_upc", upc[d], 0);
      chk("rst_rden", rden[d], 0);
    end
    rstn = 1'b1;
    @(negedge clk);

    do_op(0, 3'b110, 4'd2, 4'd5, 4'd7, 1'b1, 3, 0);
    do_op(0, 3'b010, 4'd2, 4'd5, 4'd7, 1'b1, 2, 0);
    do_op(1, 3'b110, 4'd2, 4'd5, 4'd7, 1'b1, 3, 0);
    do_op(0, 3'b110, 4'd2, 4'd5, 4'd7, 1'b0, 1, 1);
    do_op(0, 3'b110, 4'd2, 4'd5, 4'd7, 1'b0, 2, 0);
    do_op(0, 3'b111, 4'd7, 4'd5, 4'd2, 1'b1, 2, 2);
    do_op(1, 3'b100, 4'd5, 4'd2, 4'd7, 1'b0, 1, 1);
`ifdef MAT_OP_WATCHDOG_EN
    do_op(0, 3'b110, 4'd2, 4'd5, 4'd7, 1'b1, 0, 3);
`endif

    for (int i = 0; i < 16; i++) desc_mem[i] = 14'($urandom);
    for (int j = 0; j < 3; j++) desc_mem[12'h800 + 12'(j)] = 14'($urandom);
    for (int i = 0; i < 8; i++) uent_mem[i] = 8'($urandom);
    for (int t = 0; t < 8; t++) begin
      do_op(t % 2, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), int'($urandom_range(1, 5)), 0);
    end

    inst  = 16'hC000;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("async_rst_busy", busy[0], 0);
    chk("async_rst_ready", ready[0], 1);
    chk("async_rst_rden", rden[0], 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
